// File: rtl/gen_barrier_ctrl_if.sv
// Handshake bundle between the test sequencer / generator bank (master side)
// and the barrier controller (slave side).
interface gen_barrier_ctrl_if #(
  parameter int N_GEN = 4,
  parameter int CNT_W = $clog2(N_GEN + 1)
);
  logic             go;
  logic [N_GEN-1:0] gen_mask;
  logic [N_GEN-1:0] gen_start;
  logic [N_GEN-1:0] gen_done;
  logic             busy;
  logic [N_GEN-1:0] done_vec;
  logic [CNT_W-1:0] done_count;
  logic             all_done;
  logic             timeout_err;

  modport master (
    output go, gen_mask, gen_done,
    input  gen_start, busy, done_vec, done_count, all_done, timeout_err
  );

  modport slave (
    input  go, gen_mask, gen_done,
    output gen_start, busy, done_vec, done_count, all_done, timeout_err
  );
endinterface

// File: rtl/gen_barrier_ctrl.sv
// Start-all / wait-for-all barrier over a bank of stimulus generators, with a
// per-round watchdog that aborts the round if a generator never reports done.
module gen_barrier_ctrl #(
  parameter int N_GEN   = 4,
  parameter int CNT_W   = $clog2(N_GEN + 1),
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  gen_barrier_ctrl_if.slave   bus
);
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int WD_W  = WD_EN ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t           state_reg;
  logic [N_GEN-1:0] mask_reg;
  logic [N_GEN-1:0] gen_start_reg;
  logic [N_GEN-1:0] done_vec_reg;
  logic [CNT_W-1:0] done_count_reg;
  logic [WD_W-1:0]  wd_reg;
  logic             busy_reg;
  logic             all_done_reg;
  logic             timeout_err_reg;

  logic [N_GEN-1:0] new_done;
  logic [N_GEN-1:0] done_vec_next;
  logic [CNT_W-1:0] done_count_next;
  logic [WD_W-1:0]  wd_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_GEN-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_GEN; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Only first completions of enabled slots count, so the count cannot
  // exceed the number of enabled generators.
  always_comb begin
    new_done        = bus.gen_done & mask_reg & ~done_vec_reg;
    done_vec_next   = done_vec_reg | new_done;
    done_count_next = done_count_reg + popcount(new_done);
    wd_next         = wd_reg + WD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      mask_reg        <= '0;
      gen_start_reg   <= '0;
      done_vec_reg    <= '0;
      done_count_reg  <= '0;
      wd_reg          <= '0;
      busy_reg        <= 1'b0;
      all_done_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      gen_start_reg <= '0;
      all_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.go) begin
            mask_reg        <= bus.gen_mask;
            gen_start_reg   <= bus.gen_mask;
            done_vec_reg    <= '0;
            done_count_reg  <= '0;
            wd_reg          <= '0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b1;
            state_reg       <= LAUNCH;
          end
        end
        LAUNCH, WAIT: begin
          // Dones landing in the launch cycle count the same as in WAIT.
          done_vec_reg   <= done_vec_next;
          done_count_reg <= done_count_next;
          if (state_reg == WAIT) wd_reg <= wd_next;
          // Completion is tested first so it beats a coincident timeout.
          if (done_vec_next == mask_reg) begin
            all_done_reg <= 1'b1;
            state_reg    <= DONE;
          end else if (WD_EN && state_reg == WAIT && wd_next == WD_W'(TIMEOUT)) begin
            timeout_err_reg <= 1'b1;
            busy_reg        <= 1'b0;
            state_reg       <= IDLE;
          end else begin
            state_reg <= WAIT;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.gen_start   = gen_start_reg;
  assign bus.busy        = busy_reg;
  assign bus.done_vec    = done_vec_reg;
  assign bus.done_count  = done_count_reg;
  assign bus.all_done    = all_done_reg;
  assign bus.timeout_err = timeout_err_reg;
endmodule

// File: doc/gen_barrier_ctrl.md
Name: gen_barrier_ctrl

Overview:
- Launches up to N_GEN stimulus generators together, then waits for each one's done pulse, counting completions.
- Raises a single all-done pulse once every enabled generator has finished.
- This is the hardware equivalent of the bench's "start all generators, count done triggers, wait for count == N" barrier.
- Sits between the test sequencer and the generator bank, and includes a watchdog timeout for hung generators.

Parameters:
- N_GEN, 4, number of generator slots (1..32).
- CNT_W, $clog2(N_GEN+1), width of done_count.
- TIMEOUT, 1024, max cycles allowed in WAIT before error; 0 disables the watchdog.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- go  input  1  start request pulse; sampled only in IDLE.
- gen_mask  input  N_GEN  per-generator enable; sampled on accepted go.
- gen_start  output  N_GEN  one-cycle start pulse per enabled generator.
- gen_done  input  N_GEN  per-generator completion pulse; any width accepted, level treated as events.
- busy  output  1  high from accepted go until return to IDLE.
- done_vec  output  N_GEN  sticky per-generator completion flags for the current round.
- done_count  output  CNT_W  number of distinct enabled generators completed this round.
- all_done  output  1  one-cycle pulse when the barrier is satisfied.
- timeout_err  output  1  sticky watchdog error, cleared by the next accepted go.

Behaviour:
- Reset (async, immediate): state=IDLE; gen_start=0, busy=0, done_vec=0, done_count=0, all_done=0, timeout_err=0; watchdog counter=0; captured mask=0.
- Reset asserted mid-round:
  - The round is abandoned.
  - No all_done is produced.
  - All outputs go to reset values.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - go=1 → capture mask_q=gen_mask, clear done_vec/done_count/timeout_err/watchdog, go to LAUNCH.
  - busy goes high on the same edge.
- LAUNCH (exactly 1 cycle):
  - gen_start=mask_q; this is the only cycle gen_start is nonzero.
  - Next state is WAIT, or DONE directly if mask_q==0.
- WAIT:
  - Each cycle: new = gen_done & mask_q & ~done_vec.
  - done_vec |= new; done_count += popcount(new). Multiple simultaneous dones all count in the same cycle.
  - When the updated done_vec == mask_q → DONE on the next edge.
  - Duplicate dones (bit already set) are ignored.
  - Dones from masked-off slots are ignored.
- Done pulses arriving in the LAUNCH cycle itself are counted by the same rule.
- Watchdog (TIMEOUT>0):
  - Increments once per WAIT cycle.
  - If it reaches TIMEOUT while the barrier is unmet: timeout_err=1, go to IDLE, no all_done.
  - done_vec/done_count hold their values for inspection.
  - If the barrier completes in the same cycle the count hits TIMEOUT, completion wins: no error.
- DONE (1 cycle):
  - all_done=1, next state IDLE.
  - done_vec/done_count hold until the next accepted go.
- busy: 1 in LAUNCH, WAIT and DONE; 0 in IDLE.
- go outside IDLE is ignored, with no queueing; gen_mask changes after capture have no effect.
- Latency, all N dones arriving in one cycle during WAIT:
  - go edge → gen_start at +1 cycle.
  - That done cycle → all_done one cycle later.
- done_count never exceeds popcount(mask_q), and never wraps.

Test Plan:
- N_GEN=4, mask=4'b1111; go; dones on slots 2,0,3,1 in separate WAIT cycles → gen_start=4'b1111 for one cycle; done_count 1,2,3,4; all_done pulses once, one cycle after the slot-1 done; busy drops the cycle after.
- mask=4'b0101; dones on all 4 slots plus a repeated done on slot 0 → done_vec=4'b0101, done_count=2, single all_done; slots 1 and 3 never started.
- mask=4'b1111; dones on slots 0–3 all in the same cycle → done_count jumps 0→4; all_done on the next cycle.
- mask=4'b0000; go → one LAUNCH cycle with gen_start=0, then all_done; busy high for exactly 2 cycles.
- TIMEOUT=16, mask=4'b0011; only slot 0 done → after 16 WAIT cycles timeout_err=1, busy=0, no all_done, done_count=1; next go clears timeout_err.
- rst asserted mid-WAIT with done_count=2 → all outputs 0 immediately (async); a later go starts a clean round; go pulses issued while busy are ignored.
